pc_fetch_ctrl: RTL and testbench

Fetch sequencer for the program-counter register and the instruction-memory request port. It computes the PC register's next value from the following sources, highest priority first:
- trap
- branch/jump redirect
- hold
- sequential +4

It also runs a single-outstanding request/response handshake to instruction memory. Stale responses after a redirect are dropped, so the decode stage only sees instructions on the architecturally correct path.

---
 rtl/pc_fetch_ctrl_if.sv | 24 ++
 rtl/pc_fetch_ctrl.sv | 99 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus plus the decode-side delivery port
// of the fetch controller.
interface pc_fetch_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_pc;
    logic [DATA_WIDTH-1:0] if_instr;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC next-value selection and single-outstanding instruction fetch sequencer.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being truncated.
module pc_fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_1000,
    parameter logic [DATA_WIDTH-1:0] TRAP_VEC   = 32'h0000_0004
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_current,
    output logic [DATA_WIDTH-1:0] pc_next,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  trap_valid,
`ifdef PC_MISALIGN_TRAP_EN
    output logic                  misalign_exc,
`endif
    pc_fetch_ctrl_if.master       bus
);

    typedef enum logic [1:0] {BOOT, ISSUE, WAIT_RSP} state_t;

    state_t                state, state_nxt;
    logic                  kill_pending, kill_nxt;
    logic [DATA_WIDTH-1:0] issued_pc;
    logic [DATA_WIDTH-1:0] pc_seq;
    logic [DATA_WIDTH-1:0] redir_tgt;
    logic                  req_valid, hs, flush, deliver;

    assign flush = trap_valid || redirect_valid;

`ifdef PC_MISALIGN_TRAP_EN
    logic redir_bad;
    assign redir_bad    = redirect_valid && !trap_valid && (redirect_pc[1:0] != 2'b00);
    assign misalign_exc = redir_bad;
    assign redir_tgt    = redir_bad ? TRAP_VEC : redirect_pc;
`else
    assign redir_tgt    = redirect_pc & ~DATA_WIDTH'(3);
`endif

    always_comb begin
        state_nxt = state;
        kill_nxt  = kill_pending;
        req_valid = 1'b0;
        hs        = 1'b0;
        deliver   = 1'b0;
        pc_seq    = pc_current;
        case (state)
            BOOT: state_nxt = ISSUE;
            ISSUE: begin
                req_valid = !stall;
                hs        = req_valid && bus.imem_req_ready;
                if (hs) begin
                    state_nxt = WAIT_RSP;
                    pc_seq    = pc_current + DATA_WIDTH'(4);
                    // Old-path request already left; its response must be dropped.
                    kill_nxt  = flush;
                end
            end
            WAIT_RSP: begin
                if (bus.imem_rsp_valid) begin
                    state_nxt = ISSUE;
                    kill_nxt  = 1'b0;
                    deliver   = !kill_pending && !flush;
                end else if (flush) begin
                    kill_nxt = 1'b1;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        pc_next = pc_seq;
        if (rst)                 pc_next = pc_current;
        else if (trap_valid)     pc_next = TRAP_VEC;
        else if (redirect_valid) pc_next = redir_tgt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            kill_pending <= 1'b0;
            issued_pc    <= RESET_PC;
        end else begin
            state        <= state_nxt;
            kill_pending <= kill_nxt;
            if (hs) issued_pc <= pc_current;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_current;
    assign bus.if_valid       = deliver;
    assign bus.if_pc          = issued_pc;
    assign bus.if_instr       = deliver ? bus.imem_rsp_data : '0;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl: transaction-level reference model, memory
// responder with variable latency, and directed literal checks of the fetch sequence.
module tb_pc_fetch_ctrl;
    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0004;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_current, pc_next, redirect_pc;
    logic        stall, redirect_valid, trap_valid;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    pc_fetch_ctrl #(.DATA_WIDTH(DW), .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_current     (pc_current),
        .pc_next        (pc_next),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_exc   (misalign_exc),
`endif
        .bus            (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: transaction view of the fetch unit
    bit          m_boot, m_out, m_killed;
    logic [31:0] m_out_pc;
    // Memory responder
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_instr;
    int          lat_min = 1, lat_max = 1;
    // Sampled DUT outputs of the last cycle
    logic        s_req_valid, s_if_valid, s_mis;
    logic [31:0] s_addr, s_pc_next, s_if_pc, s_if_instr;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0; trap_valid = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'hdead_beef;
        pc_current = 32'h0000_1234;
        mem_busy = 1'b0; m_boot = 1'b1; m_out = 1'b0; m_killed = 1'b0;
        #1;
        chk("rst_pc_next_follows", pc_next, 32'h0000_1234);
        redirect_valid = 1'b0; redirect_pc = '0; pc_current = RESET_PC;
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_if_pc", bus.if_pc, RESET_PC);
        chk("rst_if_instr", bus.if_instr, 0);
        chk("rst_pc_next", pc_next, RESET_PC);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step(bit st, bit rdy, bit rv, logic [31:0] rpc, bit tv);
        bit          flush, e_req, e_hs, e_ifv, mis, rsp;
        logic [31:0] e_pc, rtgt;
        logic [1:0]  lo;
        @(negedge clk);
        stall = st; bus.imem_req_ready = rdy; redirect_valid = rv; redirect_pc = rpc; trap_valid = tv;
        rsp = mem_busy && (mem_wait == 1);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_instr : $urandom;
        #2;
        lo    = rpc[1:0];
        flush = tv || rv;
        e_req = !m_boot && !m_out && !st;
        e_hs  = e_req && rdy;
        e_ifv = m_out && rsp && !m_killed && !flush;
        mis   = rv && !tv && (lo != 2'b00);
        rtgt  = (MIS_EN && mis) ? TRAP_VEC : (MIS_EN ? rpc : {rpc[31:2], 2'b00});
        e_pc  = tv ? TRAP_VEC : rv ? rtgt : e_hs ? pc_current + 32'd4 : pc_current;

        s_req_valid = bus.imem_req_valid; s_addr = bus.imem_addr; s_pc_next = pc_next;
        s_if_valid = bus.if_valid; s_if_pc = bus.if_pc; s_if_instr = bus.if_instr;
        chk("req_valid", s_req_valid, e_req);
        if (e_req) chk("imem_addr", s_addr, pc_current);
        chk("pc_next", s_pc_next, e_pc);
        chk("if_valid", s_if_valid, e_ifv);
        if (e_ifv) begin
            chk("if_pc", s_if_pc, m_out_pc);
            chk("if_instr", s_if_instr, mem_instr);
        end
`ifdef PC_MISALIGN_TRAP_EN
        s_mis = misalign_exc;
        chk("misalign_exc", s_mis, mis);
`else
        s_mis = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (m_boot) m_boot = 1'b0;
        else if (e_hs) begin m_out = 1'b1; m_out_pc = pc_current; m_killed = flush; end
        else if (m_out && rsp) begin m_out = 1'b0; m_killed = 1'b0; end
        else if (m_out && flush) m_killed = 1'b1;

        if (rsp) mem_busy = 1'b0;
        else if (mem_busy) mem_wait--;
        if (s_req_valid && rdy) begin
            mem_busy  = 1'b1;
            mem_wait  = $urandom_range(lat_max, lat_min);
            mem_instr = $urandom;
        end
        pc_current = s_pc_next;
    endtask

    initial begin
        do_reset();
        // Boot then back-to-back fetch
        step(0, 1, 0, 0, 0); chk("boot_no_req", s_req_valid, 0); chk("boot_pc_next", s_pc_next, 32'h1000);
        step(0, 1, 0, 0, 0); chk("req0_addr", s_addr, 32'h1000); chk("req0_pc_next", s_pc_next, 32'h1004);
        step(0, 1, 0, 0, 0); chk("dlv0_valid", s_if_valid, 1); chk("dlv0_pc", s_if_pc, 32'h1000);
        // Memory not ready for three cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("hold_req", s_req_valid, 1); chk("hold_addr", s_addr, 32'h1004); chk("hold_pc_next", s_pc_next, 32'h1004);
        end
        step(0, 1, 0, 0, 0); chk("acc_pc_next", s_pc_next, 32'h1008);
        step(0, 1, 0, 0, 0); chk("dlv1_pc", s_if_pc, 32'h1004);
        step(0, 1, 0, 0, 0); chk("req2_addr", s_addr, 32'h1008);
        // Redirect coinciding with the response: dropped
        step(0, 1, 1, 32'h2000, 0); chk("redir_drop", s_if_valid, 0); chk("redir_pc_next", s_pc_next, 32'h2000);
        step(0, 1, 0, 0, 0); chk("redir_req_addr", s_addr, 32'h2000);
        step(0, 1, 0, 0, 0); chk("redir_dlv_pc", s_if_pc, 32'h2000); chk("redir_dlv_valid", s_if_valid, 1);
        // Redirect while waiting on a slow response: killed later
        lat_min = 3; lat_max = 3;
        step(0, 1, 0, 0, 0); chk("slow_addr", s_addr, 32'h2004);
        lat_min = 1; lat_max = 1;
        step(0, 1, 1, 32'h3000, 0); chk("kill_pc_next", s_pc_next, 32'h3000);
        step(0, 1, 0, 0, 0); chk("kill_wait_valid", s_if_valid, 0);
        step(0, 1, 0, 0, 0); chk("killed_rsp", s_if_valid, 0);
        // Trap and redirect together during a completing handshake
        step(0, 1, 1, 32'h3000, 1); chk("trap_addr", s_addr, 32'h3000); chk("trap_pc_next", s_pc_next, 32'h4);
        step(0, 1, 0, 0, 0); chk("trap_kill", s_if_valid, 0);
        // Stall two cycles
        step(1, 1, 0, 0, 0); chk("stall_req", s_req_valid, 0); chk("stall_pc", s_pc_next, 32'h4);
        step(1, 1, 0, 0, 0); chk("stall_req2", s_req_valid, 0);
        step(0, 1, 0, 0, 0); chk("resume_addr", s_addr, 32'h4); chk("resume_pc_next", s_pc_next, 32'h8);
        step(0, 1, 0, 0, 0); chk("resume_dlv", s_if_pc, 32'h4);
        // Wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC, 0); chk("wrap_redir", s_pc_next, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0); chk("wrap_addr", s_addr, 32'hFFFF_FFFC); chk("wrap_pc_next", s_pc_next, 32'h0);
        step(0, 1, 0, 0, 0); chk("wrap_dlv", s_if_pc, 32'hFFFF_FFFC);
        // Misaligned redirect target
        step(0, 0, 1, 32'h2002, 0);
        chk("mis_pc_next", s_pc_next, MIS_EN ? 32'h4 : 32'h2000);
        chk("mis_exc", s_mis, MIS_EN ? 32'h1 : 32'h0);
        step(0, 0, 0, 0, 0); chk("mis_addr", s_addr, MIS_EN ? 32'h4 : 32'h2000);

        // Random traffic with one reset in the middle of a transaction
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            if (i == 2000) do_reset();
            rpc = $urandom & ~32'd3;
            if ($urandom_range(3, 0) == 0) rpc = rpc | 32'($urandom_range(3, 1));
            step($urandom_range(3, 0) == 0, $urandom_range(9, 0) < 7,
                 $urandom_range(9, 0) == 0, rpc, $urandom_range(24, 0) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
